// File: rtl/subtract8_pkg.sv
// Shared constants for the registered ripple-borrow subtractor: default width,
// flag bundle type and the values loaded while reset is asserted.
package subtract8_pkg;

    localparam int WIDTH_DEF = 8;

    typedef struct packed {
        logic val;
        logic leq;
        logic zero;
    } flags_t;

    // Reset leaves the block looking like a completed 0 - 0.
    localparam logic   OUT_RST_BIT = 1'b0;
    localparam flags_t FLAGS_RST   = '{val: 1'b1, leq: 1'b1, zero: 1'b1};

endpackage

// File: rtl/subtract8_if.sv
// Operand/result bundle of the subtractor; the master drives operands, the
// slave (the subtractor) returns the registered difference and flags.
interface subtract8_if #(
    parameter int WIDTH = subtract8_pkg::WIDTH_DEF
);

    logic signed [WIDTH-1:0] ina;
    logic signed [WIDTH-1:0] inb;
    logic signed [WIDTH-1:0] out;
    logic                    val;
    logic                    leq;
    logic                    zero;

    modport master (output ina, inb, input out, val, leq, zero);
    modport slave  (input ina, inb, output out, val, leq, zero);

endinterface

// File: rtl/subtract8_full_sub.sv
// One-bit full subtractor: d = a - b - bin, bout set when the stage borrows.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtract8.sv
// Registered two's-complement subtractor built from a ripple-borrow chain of
// full_sub cells, with overflow, subleq-branch and zero flags.
module subtract8
    import subtract8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic         clk,
    input logic         rst_n,
    subtract8_if.slave  bus
);

    // Signed overflow: operands of opposite sign and the result took b's sign.
    function automatic logic no_overflow(input logic a_msb, input logic b_msb,
                                         input logic d_msb);
        no_overflow = !((a_msb != b_msb) && (d_msb != a_msb));
    endfunction

    logic signed [WIDTH-1:0] diff_p0;
    logic        [WIDTH:0]   borrow_p0;
    logic                    sign_ext_p0;
    logic                    unused_bout;
    flags_t                  flags_p0;

    logic signed [WIDTH-1:0] out_p1;
    flags_t                  flags_p1;

    // Stage p0: combinational borrow chain and flag derivation
    assign borrow_p0[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_sub u_fs (
            .a    (bus.ina[i]),
            .b    (bus.inb[i]),
            .bin  (borrow_p0[i]),
            .d    (diff_p0[i]),
            .bout (borrow_p0[i+1])
        );
    end

    // Extra stage on the sign-extended operands gives the exact difference's
    // sign, so leq stays correct when the WIDTH-bit result wraps.
    full_sub u_ext (
        .a    (bus.ina[WIDTH-1]),
        .b    (bus.inb[WIDTH-1]),
        .bin  (borrow_p0[WIDTH]),
        .d    (sign_ext_p0),
        .bout (unused_bout)
    );

    // The exact difference can only be zero when the wrapped one is.
    always_comb begin
        flags_p0      = FLAGS_RST;
        flags_p0.zero = (diff_p0 == '0);
        flags_p0.val  = no_overflow(bus.ina[WIDTH-1], bus.inb[WIDTH-1],
                                    diff_p0[WIDTH-1]);
        flags_p0.leq  = sign_ext_p0 | flags_p0.zero;
    end

    // Stage p1: result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1   <= {WIDTH{OUT_RST_BIT}};
            flags_p1 <= FLAGS_RST;
        end else begin
            out_p1   <= diff_p0;
            flags_p1 <= flags_p0;
        end
    end

    assign bus.out  = out_p1;
    assign bus.val  = flags_p1.val;
    assign bus.leq  = flags_p1.leq;
    assign bus.zero = flags_p1.zero;

endmodule

// File: tb/tb_subtract8.sv
// Bench for subtract8: directed corner vectors, random operands against an
// integer-arithmetic model, and asynchronous reset behaviour.
module tb_subtract8;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    subtract8_if #(.WIDTH(W)) bus ();

    subtract8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: exact integer difference, then wrap and classify.
    task automatic check_result(input string tag, input int a, input int b);
        int d;
        int wrapped;
        d       = a - b;
        wrapped = d & 255;
        check({tag, ".out"},  {24'b0, bus.out}, 32'(wrapped));
        check({tag, ".val"},  {31'b0, bus.val}, 32'(d >= -128 && d <= 127));
        check({tag, ".leq"},  {31'b0, bus.leq}, 32'(d <= 0));
        check({tag, ".zero"}, {31'b0, bus.zero}, 32'(wrapped == 0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".out"},  {24'b0, bus.out}, 32'h0);
        check({tag, ".val"},  {31'b0, bus.val}, 32'h1);
        check({tag, ".leq"},  {31'b0, bus.leq}, 32'h1);
        check({tag, ".zero"}, {31'b0, bus.zero}, 32'h1);
    endtask

    task automatic apply(input string tag, input int a, input int b);
        bus.ina = 8'(a);
        bus.inb = 8'(b);
        @(posedge clk);
        #1;
        check_result(tag, a, b);
    endtask

    initial begin
        logic signed [7:0] ra;
        logic signed [7:0] rb;

        bus.ina = 8'sd33;
        bus.inb = 8'sd5;
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_async");
        repeat (2) @(posedge clk);
        #1 check_reset_state("rst_held");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check_result("rst_first", 33, 5);

        apply("v125_m123", 125, -123);
        apply("vm110_m9", -110, -9);
        apply("v125_0", 125, 0);
        apply("v12_25", 12, 25);
        apply("v15_12", 15, 12);
        apply("vm126_12", -126, 12);
        apply("vm125_125", -125, 125);
        apply("v77_77", 77, 77);
        apply("vm128_1", -128, 1);
        apply("v127_m1", 127, -1);
        apply("vm128_m128", -128, -128);
        apply("v0_m128", 0, -128);

        // Operands changing between edges must not disturb held outputs.
        apply("hold_pre", 40, 50);
        bus.ina = 8'sd100;
        bus.inb = -8'sd100;
        #3 check_result("hold", 40, 50);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 50 == 0) ra = -8'sd128;
            if (i % 50 == 25) rb = 8'sd127;
            apply("rand", int'(ra), int'(rb));
        end

        // Mid-stream reset: in-flight result discarded, next edge loads live operands.
        apply("mid_pre", 125, 0);
        bus.ina = 8'sd20;
        bus.inb = 8'sd7;
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_async");
        @(posedge clk);
        #1 check_reset_state("mid_held");
        #2 rst_n = 1'b1;
        #1 check_reset_state("mid_release");
        @(posedge clk);
        #1 check_result("mid_first", 20, 7);
        apply("mid_next", -3, 90);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/subtract8.md
SUBTRACT8 -- requirements
Module: subtract8

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; all values below assume 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ina  input  8  minuend, two's-complement signed.
REQ-005 inb  input  8  subtrahend, two's-complement signed.
REQ-006 out  output  8  registered difference ina - inb, wrapped to 8 bits.
REQ-007 val  output  1  registered validity flag; 1 = no signed overflow in out.
REQ-008 leq  output  1  registered flag; 1 = exact (unbounded) difference <= 0, the subleq branch condition.
REQ-009 zero  output  1  registered flag; 1 = out equals 0.

Function
REQ-010 Each rising clk edge with rst_n high SHALL sample ina/inb and load out = (ina - inb) mod 256.
REQ-011 Latency SHALL be exactly one clock: outputs reflect operands present before the previous rising edge; no handshake, one result per cycle.
REQ-012 val SHALL be 0 when ina and inb have different sign bits and the sign of out differs from ina's sign; otherwise 1.
REQ-013 leq SHALL be computed from the 9-bit sign-extended exact difference: 1 when its sign bit is 1 or it equals 0; correct even on overflow.
REQ-014 zero SHALL be 1 only when all 8 bits of out are 0.
REQ-015 Full range SHALL be supported: -128 - 1 gives out = 127, val = 0, leq = 1; 127 - (-1) gives out = -128, val = 0, leq = 0.
REQ-016 ina == inb SHALL give out = 0, val = 1, leq = 1, zero = 1.
REQ-017 Outputs SHALL hold between edges; operand changes between edges SHALL have no effect until the next edge.

Reset
REQ-018 rst_n low SHALL immediately, independent of clk, force out = 0, val = 1, leq = 1, zero = 1.
REQ-019 While rst_n is low, clk edges SHALL not update outputs; the first rising edge after rst_n rises SHALL load the current operands normally.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; no stale value reappears after release.

Structure
REQ-021 The difference SHALL be formed as a ripple-borrow chain of WIDTH instances of one sub-module, full_sub (inputs a, b, bin; outputs d, bout).
REQ-022 The 9th (sign-extension) stage for leq SHALL reuse full_sub.
REQ-023 WIDTH default and the reset values of out and the flags SHALL live in a shared package, subtract8_pkg.
REQ-024 All flags SHALL be derived combinationally from the chain and registered alongside out; no other state.

Verification
REQ-025 ina = 125, inb = -123 -> next cycle out = -8 (0xF8), val = 0, leq = 0, zero = 0.
REQ-026 ina = -110, inb = -9 -> out = -101 (0x9B), val = 1, leq = 1; ina = 125, inb = 0 -> out = 125, val = 1, leq = 0.
REQ-027 ina = 12, inb = 25 -> out = -13 (0xF3), val = 1, leq = 1; ina = 15, inb = 12 -> out = 3, val = 1, leq = 0.
REQ-028 ina = -126, inb = 12 -> out = 118 (0x76), val = 0, leq = 1; ina = -125, inb = 125 -> out = 6, val = 0, leq = 1.
REQ-029 ina = inb = 77 -> out = 0, zero = 1, leq = 1, val = 1.
REQ-030 rst_n pulsed low between clock edges while out = 125 -> out = 0 and flags at reset values at once; first edge after release loads the current operands.
